// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous-read buffer memory among NUM_REQ
// decoder clients, with a per-client burst lock and a registered one-hot read-response strobe.
module mem_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8192,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_wen_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] req_mask_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_wen_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic [MASK_WIDTH-1:0]         mem_mask_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int SUM_WIDTH = IDX_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e                 state_r;
  logic [IDX_WIDTH-1:0]   ptr_r;
  logic [IDX_WIDTH-1:0]   owner_r;
  logic [NUM_REQ-1:0]     rsp_valid_r;

  logic [NUM_REQ-1:0]     grant_s;
  logic [IDX_WIDTH-1:0]   gidx_s;
  logic [IDX_WIDTH-1:0]   cand_s;
  logic [IDX_WIDTH-1:0]   ptr_nxt_s;
  logic [SUM_WIDTH-1:0]   sum_s;
  logic                   found_s;
  logic                   take_s;
  logic                   grant_any_s;
  logic                   lock_g_s;
  logic                   wen_g_s;
  logic [ADDR_WIDTH-1:0]  addr_s;
  logic [DATA_WIDTH-1:0]  wdata_s;
  logic [MASK_WIDTH-1:0]  mask_s;

  // Grant selection: locked owner only, otherwise first valid client at or after ptr_r
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    cand_s  = '0;
    sum_s   = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    case (state_r)
      ST_LOCK: begin
        grant_s[owner_r] = req_valid_i[owner_r];
        gidx_s           = owner_r;
      end
      default: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          // Modulo wrap keeps the search inside 0..NUM_REQ-1 for non-power-of-two counts
          sum_s   = {1'b0, ptr_r} + SUM_WIDTH'(i);
          sum_s   = (sum_s >= SUM_WIDTH'(NUM_REQ)) ? (sum_s - SUM_WIDTH'(NUM_REQ)) : sum_s;
          cand_s  = sum_s[IDX_WIDTH-1:0];
          take_s  = !found_s && req_valid_i[cand_s];
          grant_s[cand_s] = grant_s[cand_s] | take_s;
          gidx_s  = take_s ? cand_s : gidx_s;
          found_s = found_s | take_s;
        end
      end
    endcase
  end

  assign grant_any_s = |grant_s;
  assign lock_g_s    = |(grant_s & req_lock_i);
  assign wen_g_s     = |(grant_s & req_wen_i);
  assign ptr_nxt_s   = (gidx_s == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : (gidx_s + IDX_WIDTH'(1));

  // Memory port mux: AND-OR of the one-hot grant, so an idle port drives all zeros
  always_comb begin
    addr_s  = '0;
    wdata_s = '0;
    mask_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_s  = addr_s  | ({ADDR_WIDTH{grant_s[k]}} & req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
      wdata_s = wdata_s | ({DATA_WIDTH{grant_s[k]}} & req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH]);
      mask_s  = mask_s  | ({MASK_WIDTH{grant_s[k]}} & req_mask_i[k*MASK_WIDTH +: MASK_WIDTH]);
    end
  end

  // Arbitration FSM: state, round-robin pointer, burst owner and read-response strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_ARB;
      ptr_r       <= '0;
      owner_r     <= '0;
      rsp_valid_r <= '0;
    end else begin
      rsp_valid_r <= (grant_any_s && !wen_g_s) ? grant_s : {NUM_REQ{1'b0}};
      if (grant_any_s) begin
        if (lock_g_s) begin
          state_r <= ST_LOCK;
          owner_r <= gidx_s;
        end else begin
          state_r <= ST_ARB;
          ptr_r   <= ptr_nxt_s;
        end
      end
    end
  end

  assign req_ready_o = grant_s;
  assign mem_req_o   = grant_any_s;
  assign mem_wen_o   = wen_g_s;
  assign mem_addr_o  = addr_s;
  assign mem_wdata_o = wdata_s;
  assign mem_mask_o  = mask_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = mem_rdata_i;

  mem_rr_arbiter_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_valid (req_valid_i),
    .req_ready (grant_s),
    .rsp_valid (rsp_valid_r)
  );

endmodule

// Protocol checks on the grant and response vectors of mem_rr_arbiter.
module mem_rr_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic [NUM_REQ-1:0] rsp_valid
);

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready));
  a_rsp_onehot0:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid));
  a_ready_valid:   assert property (@(posedge clk_i) disable iff (rst_i)
                                    ((req_ready & ~req_valid) == {NUM_REQ{1'b0}}));

endmodule
